// File: rtl/bias_stage_pkg.sv
// Shared constants, FSM state type and the bias-add helper for the bias stage.
package bias_stage_pkg;

   localparam int ACC_W = 34;
   localparam int OUT_W = ACC_W + 1;
   localparam int N_CH  = 4;
   localparam int CH_W  = 2;
   localparam int LEN_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Zero-extend both operands so the carry lands in the extra output bit.
   function automatic logic [OUT_W-1:0] bias_add(input logic [ACC_W-1:0] acc,
                                                  input logic [ACC_W-1:0] bias);
      return {1'b0, acc} + {1'b0, bias};
   endfunction

endpackage

// File: rtl/bias_stage_ctrl_regfile.sv
// Four-entry per-channel bias register file; writes are locked out while a frame runs.
module bias_regfile
   import bias_stage_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [CH_W-1:0]  addr,
   input  logic [ACC_W-1:0] data,
   input  logic             busy,
   input  logic [CH_W-1:0]  rd_addr,
   output logic [ACC_W-1:0] rd_data
);

   logic [ACC_W-1:0] regs [N_CH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            regs[i] <= '0;
         end
      end else if (we && !busy) begin
         regs[addr] <= data;
      end
   end

   assign rd_data = regs[rd_addr];

endmodule

// File: rtl/bias_stage_ctrl.sv
// Bias-add stage sequencer: per-frame FSM, channel/pixel counters and registered output.
module bias_stage_ctrl
   import bias_stage_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_we,
   input  logic [CH_W-1:0]  cfg_addr,
   input  logic [ACC_W-1:0] cfg_data,
   input  logic             start,
   input  logic [LEN_W-1:0] frame_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ACC_W-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [CH_W-1:0]  out_ch,
   output logic             out_last,
   output logic             busy,
   output logic             done
);

   state_t           state;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] pix_cnt;
   logic [CH_W-1:0]  ch_cnt;
   logic [ACC_W-1:0] bias_rd;
   logic             accept;
   logic             out_fire;
   logic             last_beat;

   assign busy      = (state == RUN) || (state == DRAIN);
   assign done      = (state == DONE);
   assign in_ready  = (state == RUN) && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   assign last_beat = (ch_cnt == CH_W'(N_CH - 1)) && (pix_cnt == len_q - LEN_W'(1));

   bias_regfile u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (cfg_we),
      .addr    (cfg_addr),
      .data    (cfg_data),
      .busy    (busy),
      .rd_addr (ch_cnt),
      .rd_data (bias_rd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         len_q   <= '0;
         pix_cnt <= '0;
         ch_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (frame_len != '0) begin
                     len_q   <= frame_len;
                     pix_cnt <= '0;
                     ch_cnt  <= '0;
                     state   <= RUN;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            RUN: begin
               if (accept) begin
                  ch_cnt <= ch_cnt + CH_W'(1);
                  if (ch_cnt == CH_W'(N_CH - 1)) begin
                     pix_cnt <= pix_cnt + LEN_W'(1);
                  end
                  if (last_beat) begin
                     state <= DRAIN;
                  end
               end
            end
            // Only the final beat can still be pending here.
            DRAIN: begin
               if (out_fire && out_last) begin
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output register: reload on accept (even while draining), else clear valid on handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         out_last  <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= bias_add(in_data, bias_rd);
         out_ch    <= ch_cnt;
         out_last  <= last_beat;
      end else if (out_fire) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule
